// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round count, Rcon table and GF(2^8) xtime.
package aes_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } aes_state_e;

    localparam int unsigned NR = 10;

    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round numbers outside 1..NR yield zero so idle/done counter values are harmless.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        return (round >= 4'd1 && round <= 4'd10) ? RCON[round - 4'd1] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes128_top.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional AES_COMPLEMENT_OUT_EN adds registered complementary data/valid outputs.
module aes128_top
    import aes_pkg::*;
(
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
`ifdef AES_COMPLEMENT_OUT_EN
    ,
    output logic         AES_data_out_complementary_valid,
    output logic [127:0] AES_data_out_complementary
`endif
);

    localparam logic [3:0] LAST_RND = 4'(NR);
    localparam logic [3:0] DONE_RND = 4'(NR + 1);

    aes_state_e   fsm_q;
    logic [127:0] state_q, key_q, data_out_q;
    logic [3:0]   round_q;
    logic         valid_q;
`ifdef AES_COMPLEMENT_OUT_EN
    logic [127:0] comp_q;
    logic         comp_valid_q;
`endif

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [7:0]   sw [4];
    logic [31:0]  rot_w, temp, nk0, nk1, nk2, nk3;
    logic [127:0] key_d, round_d;

    for (genvar i = 0; i < 16; i++) begin : g_subbytes
        aes_sbox u_sbox (.data_i(state_q[127-8*i -: 8]), .data_o(sb[i]));
    end

    assign rot_w = {key_q[23:0], key_q[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (.data_i(rot_w[31-8*i -: 8]), .data_o(sw[i]));
    end

    always_comb begin
        temp  = {sw[0], sw[1], sw[2], sw[3]} ^ {rcon(round_q), 24'h0};
        nk0   = key_q[127:96] ^ temp;
        nk1   = key_q[95:64]  ^ nk0;
        nk2   = key_q[63:32]  ^ nk1;
        nk3   = key_q[31:0]   ^ nk2;
        key_d = {nk0, nk1, nk2, nk3};
    end

    // Byte i sits at row i%4, column i/4; ShiftRows rotates row r left by r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c + r] = sb[4*((c + r) % 4) + r];
        end
        assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign round_d[127-8*i -: 8] = ((round_q == LAST_RND) ? sr[i] : mc[i]) ^ key_d[127-8*i -: 8];
    end

    // Counter value NR+1 is the result edge: state already holds the ciphertext.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            fsm_q      <= ST_IDLE;
            state_q    <= '0;
            key_q      <= '0;
            round_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
`ifdef AES_COMPLEMENT_OUT_EN
            comp_q       <= '1;
            comp_valid_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef AES_COMPLEMENT_OUT_EN
            comp_valid_q <= 1'b0;
`endif
            case (fsm_q)
                ST_IDLE: begin
                    if (AES_en) begin
                        state_q <= AES_data_in ^ AES_key_in;
                        key_q   <= AES_key_in;
                        round_q <= 4'd1;
                        fsm_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (round_q == DONE_RND) begin
                        data_out_q <= state_q;
                        valid_q    <= 1'b1;
`ifdef AES_COMPLEMENT_OUT_EN
                        comp_q       <= ~state_q;
                        comp_valid_q <= 1'b1;
`endif
                        round_q    <= '0;
                        fsm_q      <= ST_IDLE;
                    end else begin
                        state_q <= round_d;
                        key_q   <= key_d;
                        round_q <= round_q + 4'd1;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign AES_data_out       = data_out_q;
    assign AES_data_out_valid = valid_q;
`ifdef AES_COMPLEMENT_OUT_EN
    assign AES_data_out_complementary       = comp_q;
    assign AES_data_out_complementary_valid = comp_valid_q;
`endif

endmodule

// File: tb/tb_aes128_top.sv
// Self-checking bench for aes128_top: FIPS vectors, random blocks vs a reference model,
// continuous mode, mid-run reset; complement outputs checked when AES_COMPLEMENT_OUT_EN is set.
module tb_aes128_top;

    logic         AES_clk = 1'b0;
    logic         AES_rst = 1'b1;
    logic         AES_en  = 1'b0;
    logic [127:0] AES_data_in = '0;
    logic [127:0] AES_key_in  = '0;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
`ifdef AES_COMPLEMENT_OUT_EN
    logic         AES_data_out_complementary_valid;
    logic [127:0] AES_data_out_complementary;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sbox_t [256];

    always #5 AES_clk = ~AES_clk;

    aes128_top dut (
        .AES_clk            (AES_clk),
        .AES_rst            (AES_rst),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid)
`ifdef AES_COMPLEMENT_OUT_EN
        ,
        .AES_data_out_complementary_valid (AES_data_out_complementary_valid),
        .AES_data_out_complementary       (AES_data_out_complementary)
`endif
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Polynomial product modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c + row] = t[4*((c + row) % 4) + row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = s[4*c + k];
                    for (int k = 0; k < 4; k++)
                        s[4*c + k] = gmul(8'h02, a[k]) ^ gmul(8'h03, a[(k+1)%4]) ^ a[(k+2)%4] ^ a[(k+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One-cycle start pulse; inputs are scrambled after the start edge.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             output logic [127:0] ct, output int lat);
        lat = -1;
        ct  = '0;
        @(negedge AES_clk);
        AES_key_in  = key;
        AES_data_in = pt;
        AES_en      = 1'b1;
        @(posedge AES_clk);
        @(negedge AES_clk);
        AES_en      = 1'b0;
        AES_key_in  = rand128();
        AES_data_in = rand128();
        for (int c = 1; c <= 20; c++) begin
            @(posedge AES_clk);
            #1;
            if (AES_data_out_valid) begin
                lat = c;
                ct  = AES_data_out;
                break;
            end
        end
    endtask

    task automatic chk_comp(input string name, input logic [127:0] exp_ct);
`ifdef AES_COMPLEMENT_OUT_EN
        chk({name, "_comp_data"}, AES_data_out_complementary, ~exp_ct);
        chk({name, "_comp_valid"}, 128'(AES_data_out_complementary_valid), 128'(AES_data_out_valid));
`else
        if (exp_ct === 'x) $display("no complement outputs in %s", name);
`endif
    endtask

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        vec_t         vecs [3];
        logic [127:0] got, k, p;
        int           lat;
        int           pulses [$];
        int           exp_pulse [5];
        int           quiet_pulses;

        vecs[0] = '{"appB", APPB_KEY, APPB_PT, APPB_CT};
        vecs[1] = '{"c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{"zero", '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        exp_pulse = '{11, 23, 35, 47, 59};

        build_sbox();

        repeat (2) @(posedge AES_clk);
        #1;
        chk("reset_data", AES_data_out, '0);
        chk("reset_valid", 128'(AES_data_out_valid), '0);
`ifdef AES_COMPLEMENT_OUT_EN
        chk("reset_comp_data", AES_data_out_complementary, '1);
        chk("reset_comp_valid", 128'(AES_data_out_complementary_valid), '0);
`endif
        @(negedge AES_clk);
        AES_rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            chk({vecs[i].name, "_model"}, aes_model(vecs[i].key, vecs[i].pt), vecs[i].ct);
            run_block(vecs[i].key, vecs[i].pt, got, lat);
            chk({vecs[i].name, "_ct"}, got, vecs[i].ct);
            chk({vecs[i].name, "_latency"}, 128'(lat), 128'(11));
            chk_comp(vecs[i].name, vecs[i].ct);
            @(posedge AES_clk);
            #1;
            chk({vecs[i].name, "_pulse_width"}, 128'(AES_data_out_valid), '0);
            chk({vecs[i].name, "_hold"}, AES_data_out, vecs[i].ct);
        end

        for (int i = 0; i < 8; i++) begin
            k = rand128();
            p = rand128();
            run_block(k, p, got, lat);
            chk($sformatf("rand%0d_ct", i), got, aes_model(k, p));
            chk($sformatf("rand%0d_latency", i), 128'(lat), 128'(11));
        end

        // Continuous mode: AES_en high for 51 start-capable edges, the block started
        // on edge 48 still drains after AES_en drops.
        @(negedge AES_clk);
        AES_key_in  = APPB_KEY;
        AES_data_in = APPB_PT;
        for (int cyc = 0; cyc < 71; cyc++) begin
            AES_en = (cyc <= 50);
            @(posedge AES_clk);
            #1;
            if (AES_data_out_valid) begin
                pulses.push_back(cyc);
                chk($sformatf("cont_ct_at_%0d", cyc), AES_data_out, APPB_CT);
            end
            @(negedge AES_clk);
        end
        chk("cont_pulse_count", 128'(pulses.size()), 128'(5));
        for (int j = 0; j < 5; j++)
            if (j < pulses.size())
                chk($sformatf("cont_pulse%0d_cycle", j), 128'(pulses[j]), 128'(exp_pulse[j]));

        quiet_pulses = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            AES_data_in = (cyc % 2 == 0) ? 128'ha6f2daeb140fa720529e75d521cbc681 : rand128();
            @(posedge AES_clk);
            #1;
            if (AES_data_out_valid) quiet_pulses++;
            @(negedge AES_clk);
        end
        chk("idle_toggle_pulses", 128'(quiet_pulses), '0);
        chk("idle_toggle_data", AES_data_out, APPB_CT);

        // Reset after the fifth round edge aborts the block.
        AES_key_in  = APPB_KEY;
        AES_data_in = APPB_PT;
        AES_en      = 1'b1;
        @(posedge AES_clk);
        @(negedge AES_clk);
        AES_en = 1'b0;
        repeat (5) @(posedge AES_clk);
        @(negedge AES_clk);
        AES_rst = 1'b1;
        @(posedge AES_clk);
        #1;
        chk("midrst_data", AES_data_out, '0);
        chk("midrst_valid", 128'(AES_data_out_valid), '0);
`ifdef AES_COMPLEMENT_OUT_EN
        chk("midrst_comp_data", AES_data_out_complementary, '1);
`endif
        @(negedge AES_clk);
        AES_rst = 1'b0;
        quiet_pulses = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(posedge AES_clk);
            #1;
            if (AES_data_out_valid) quiet_pulses++;
        end
        chk("midrst_no_pulse", 128'(quiet_pulses), '0);
        chk("midrst_data_after", AES_data_out, '0);

        run_block(APPB_KEY, APPB_PT, got, lat);
        chk("restart_ct", got, APPB_CT);
        chk("restart_latency", 128'(lat), 128'(11));
        chk_comp("restart", APPB_CT);

        repeat (2) @(posedge AES_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
